// File: rtl/load_store_unit.sv
// load_store_unit
//   MEM-stage data-memory access unit. It takes a load or store from the
//   EX/MEM register, runs one req/ack transaction on the data bus, and aligns
//   the data on the way out and on the way back. While the access is in
//   flight it holds the pipeline with StallM. It also flags misaligned or
//   illegal accesses and accesses that time out.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   MemReadM, MemWriteM         load / store in MEM (mutually exclusive)
//   Funct3M                     size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUResultM, WriteDataM      byte address, LSB-justified store data
//   ReadDataM                   formatted load result (registered)
//   StallM                      hold IF..MEM while an access is pending
//   AccessFaultM                misaligned/illegal access (combinational)
//   BusErrM                     current access timed out (valid in DONE)
//   mem_req/we/addr/wdata/wstrb registered bus request
//   mem_ack, mem_rdata          one-cycle completion, read word
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255  // 1..65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        AccessFaultM,
    output logic        BusErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] read_data_q, read_data_d;
    logic        bus_err_q, bus_err_d;

    logic        mem_op, bad, access;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;

    // Select the byte/half addressed by the saved offset and extend it.
    function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rd >> {off, 3'b000});
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  format_load = {{24{b[7]}}, b};
            3'b001:  format_load = {{16{h[15]}}, h};
            3'b100:  format_load = {24'b0, b};
            3'b101:  format_load = {16'b0, h};
            default: format_load = rd;
        endcase
    endfunction

    // Fault decode. BU/HU exist only for loads.
    always_comb begin
        // NOTE: every signal gets a value on every path through always_comb,
        // otherwise synthesis infers a latch to remember the old value.
        bad = 1'b1;
        case (Funct3M)
            3'b000:  bad = 1'b0;
            3'b001:  bad = ALUResultM[0];
            3'b010:  bad = |ALUResultM[1:0];
            3'b100:  bad = MemWriteM;
            3'b101:  bad = MemWriteM | ALUResultM[0];
            default: bad = 1'b1;
        endcase
    end

    assign mem_op       = MemReadM | MemWriteM;
    assign AccessFaultM = mem_op & bad;
    assign access       = mem_op & ~bad;

    // Store formatting: replicate the data across lanes so the byte enables
    // alone choose where it lands.
    always_comb begin
        st_wdata = 32'b0;
        st_wstrb = 4'b0000;
        if (MemWriteM) begin
            case (Funct3M[1:0])
                2'b00: begin
                    st_wdata = {4{WriteDataM[7:0]}};
                    st_wstrb = 4'b0001 << ALUResultM[1:0];
                end
                2'b01: begin
                    st_wdata = {2{WriteDataM[15:0]}};
                    st_wstrb = ALUResultM[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    st_wdata = WriteDataM;
                    st_wstrb = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        bus_err_d   = bus_err_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWriteM;
                    mem_addr_d  = {ALUResultM[31:2], 2'b00};
                    mem_wdata_d = st_wdata;
                    mem_wstrb_d = st_wstrb;
                    off_d       = ALUResultM[1:0];
                    funct3_d    = Funct3M;
                    cnt_d       = 16'd0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b0;
                    if (!mem_we_q) read_data_d = format_load(funct3_q, off_q, mem_rdata);
                    state_d   = DONE;
                end else if (cnt_q == LAST_CNT) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (!mem_we_q) read_data_d = 32'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin  // DONE: the instruction leaves MEM at the end of this cycle
                bus_err_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'b0;
            mem_wdata_q <= 32'b0;
            mem_wstrb_q <= 4'b0;
            off_q       <= 2'b0;
            funct3_q    <= 3'b0;
            cnt_q       <= 16'd0;
            read_data_q <= 32'b0;
            bus_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, regardless of statement order.
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Reset forces the stall low straight away, even while an instruction is
    // still sitting in MEM.
    assign StallM    = ~reset & (((state_q == IDLE) & access) | (state_q == BUSY));
    assign ReadDataM = read_data_q;
    assign BusErrM   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. The bench acts as the data memory:
// it answers each request after a chosen number of wait cycles (or never, to
// force a timeout). A word-array memory and an arithmetic reference model
// give the expected bus values, load results, stall lengths and faults.
module tb_load_store_unit;

    localparam int T = 4;  // TIMEOUT_CYCLES used for the DUT

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, AccessFaultM, BusErrM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mem [16];   // word memory indexed by address bits [5:2]
    logic [31:0] rd_exp;     // expected ReadDataM

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .AccessFaultM(AccessFaultM),
        .BusErrM(BusErrM), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_fault(input bit ld, input int f3, input int a);
        case (f3)
            0:       return 1'b0;
            1:       return (a % 2) != 0;
            2:       return (a % 4) != 0;
            4:       return !ld;
            5:       return !ld || ((a % 2) != 0);
            default: return 1'b1;
        endcase
    endfunction

    // Expected load value from the rules: pick the addressed byte/half by
    // shifting and masking, then extend it.
    function automatic logic [31:0] exp_load(input int f3, input int a, input logic [31:0] word);
        int unsigned v;
        case (f3)
            0, 4: begin
                v = (word >> (8 * (a % 4))) & 32'hFF;
                if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
            end
            1, 5: begin
                v = (word >> (16 * ((a % 4) / 2))) & 32'hFFFF;
                if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    task automatic nop();
        MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
        ALUResultM = 32'b0; WriteDataM = 32'b0;
    endtask

    // One instruction in MEM. waits = BUSY cycles before the ack; waits >= T
    // means the memory never answers.
    task automatic run_op(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int waits);
        bit          flt, timed_out;
        int          stalls, idx;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        @(negedge clk);
        MemReadM = ld; MemWriteM = !ld; Funct3M = f3;
        ALUResultM = addr; WriteDataM = wd; mem_ack = 1'b0;
        #1;
        flt = exp_fault(ld, int'(f3), int'(addr[1:0]));
        check("access_fault", AccessFaultM, 32'(flt));
        if (flt) begin
            check("fault_no_stall", StallM, 0);
            @(negedge clk);
            check("fault_no_req", mem_req, 0);
            check("fault_rdata_held", ReadDataM, rd_exp);
            return;
        end
        idx     = int'(addr[5:2]);
        e_addr  = addr & 32'hFFFF_FFFC;
        e_wdata = 0;
        e_wstrb = 0;
        if (!ld) begin
            case (int'(f3))
                0: begin e_wdata = wd[7:0] * 32'h0101_0101;  e_wstrb = 4'(1 << (addr % 4)); end
                1: begin e_wdata = wd[15:0] * 32'h0001_0001; e_wstrb = 4'(3 << (addr % 4)); end
                default: begin e_wdata = wd; e_wstrb = 4'hF; end
            endcase
        end
        stalls    = int'(StallM);
        timed_out = 1'b1;
        for (int c = 0; c < T; c++) begin
            @(negedge clk);
            stalls += int'(StallM);
            check("busy_req", mem_req, 1);
            check("busy_we", mem_we, 32'(!ld));
            check("busy_addr", mem_addr, e_addr);
            check("busy_wdata", mem_wdata, e_wdata);
            check("busy_wstrb", mem_wstrb, e_wstrb);
            if (c == waits) begin
                mem_ack   = 1'b1;
                mem_rdata = ld ? mem[idx] : $urandom;
                timed_out = 1'b0;
                break;
            end
        end
        @(negedge clk);  // DONE
        mem_ack = 1'b0;
        if (ld) rd_exp = timed_out ? 32'b0 : exp_load(int'(f3), int'(addr[1:0]), mem[idx]);
        if (!ld && !timed_out)
            for (int i = 0; i < 4; i++)
                if (e_wstrb[i]) mem[idx][8*i +: 8] = e_wdata[8*i +: 8];
        check("done_no_stall", StallM, 0);
        check("done_req_low", mem_req, 0);
        check("done_bus_err", BusErrM, 32'(timed_out));
        check("done_rdata", ReadDataM, rd_exp);
        check("stall_cycles", stalls, timed_out ? T + 1 : waits + 2);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        rd_exp = 32'b0;
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'b0;
        nop();
        repeat (2) @(negedge clk);
        check("rst_rdata", ReadDataM, 0);
        check("rst_bus_err", BusErrM, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_wstrb", mem_wstrb, 0);
        check("rst_stall", StallM, 0);
        reset = 1'b0;

        // LB / LBU at 0x103 of 0x80FF1234
        mem[0] = 32'h80FF_1234;
        run_op(1'b1, 3'b000, 32'h0000_0103, 32'h0, 0);
        check("lb_value", ReadDataM, 32'hFFFF_FF80);
        run_op(1'b1, 3'b100, 32'h0000_0103, 32'h0, 0);
        check("lbu_value", ReadDataM, 32'h0000_0080);

        // SH at 0x202 with three wait cycles
        run_op(1'b0, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 3);
        check("sh_merged", mem[0], 32'hBEEF_1234);

        // Faulting accesses
        run_op(1'b1, 3'b010, 32'h0000_0006, 32'h0, 0);
        check("lw_mis_held", ReadDataM, 32'h0000_0080);
        run_op(1'b0, 3'b100, 32'h0000_0010, 32'h55, 0);

        // LH at 0x10 that never gets an ack
        run_op(1'b1, 3'b001, 32'h0000_0010, 32'h0, T);
        check("lh_timeout_zero", ReadDataM, 32'h0);

        // Back-to-back SW then LW at 0x0
        run_op(1'b0, 3'b010, 32'h0000_0000, 32'hCAFE_F00D, 1);
        run_op(1'b1, 3'b010, 32'h0000_0000, 32'h0, 0);
        check("sw_lw_value", ReadDataM, 32'hCAFE_F00D);

        // Reset in the middle of BUSY, then a stray ack
        @(negedge clk);
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h24;
        @(negedge clk);
        check("mid_busy_req", mem_req, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_stall", StallM, 0);
        check("mid_rst_rdata", ReadDataM, 0);
        rd_exp = 32'b0;
        @(negedge clk);
        reset = 1'b0; nop();
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_req", mem_req, 0);
        check("late_ack_stall", StallM, 0);
        check("late_ack_rdata", ReadDataM, 0);
        @(negedge clk);
        check("late_ack_idle_req", mem_req, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            bit          ld;
            logic [2:0]  f3;
            logic [31:0] a;
            ld = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'({$urandom_range(0, 1), 2'b00} | 3'($urandom_range(0, 2)));
            a  = {$urandom_range(0, 3) == 0 ? 26'($urandom) : 26'b0, 6'($urandom)};
            run_op(ld, f3, a, $urandom, $urandom_range(0, 9) == 0 ? T : $urandom_range(0, 3));
        end

        @(negedge clk);
        nop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
